// File: rtl/reg_file_wb_if.sv
// Register-file bus: write-back port plus two decode read ports.
interface reg_file_wb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              x0_write_err;

    // Core side: drives write-back and read indices.
    modport master (
        output reg_write, rd, write_data, rs1, rs2,
        input  read_data1, read_data2, x0_write_err
    );

    // Register-file side.
    modport slave (
        input  reg_write, rd, write_data, rs1, rs2,
        output read_data1, read_data2, x0_write_err
    );
endinterface

// File: rtl/reg_file_wb.sv
// Integer register file with write-through bypass on both read ports.
// x0 reads as zero; writes to it only raise a sticky debug flag.
module reg_file_wb #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          ADDR_W   = 5,
    parameter bit                   BYPASS   = 1'b1,
    parameter logic [DATA_W-1:0]    SP_RESET = '0
) (
    input logic          clk,
    input logic          rst,
    reg_file_wb_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_x0_write_err;
    logic [DATA_W-1:0] w_read_data1;
    logic [DATA_W-1:0] w_read_data2;
    logic              w_wr_x0;
    logic              w_wr_reg;

    assign w_wr_x0  = bus.reg_write && (bus.rd == '0);
    assign w_wr_reg = bus.reg_write && (bus.rd != '0);

    // Storage: async reset to 0 (SP_RESET for x2); entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i[ADDR_W-1:0]] <= (i == 32'd2) ? SP_RESET : '0;
            end
        end else if (w_wr_reg) begin
            r_regs[bus.rd] <= bus.write_data;
        end
    end

    // Sticky flag for attempted x0 writes, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0_write_err <= 1'b0;
        end else if (w_wr_x0) begin
            r_x0_write_err <= 1'b1;
        end
    end

    // Read port 1: zero for x0, bypass beats storage, bypass off while in reset.
    always_comb begin
        w_read_data1 = r_regs[bus.rs1];
        if (BYPASS && !rst && w_wr_reg && (bus.rd == bus.rs1)) begin
            w_read_data1 = bus.write_data;
        end
        if (bus.rs1 == '0) begin
            w_read_data1 = '0;
        end
    end

    // Read port 2: same resolution as port 1, independently.
    always_comb begin
        w_read_data2 = r_regs[bus.rs2];
        if (BYPASS && !rst && w_wr_reg && (bus.rd == bus.rs2)) begin
            w_read_data2 = bus.write_data;
        end
        if (bus.rs2 == '0) begin
            w_read_data2 = '0;
        end
    end

    assign bus.read_data1   = w_read_data1;
    assign bus.read_data2   = w_read_data2;
    assign bus.x0_write_err = r_x0_write_err;
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench: a BYPASS=1 and a BYPASS=0 instance see identical stimulus,
// expectations come from an array model and are checked by a separate monitor.
module tb_reg_file_wb;
    localparam logic [31:0] SP = 32'h8000_0FF0;

    logic clk;
    logic rst;

    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) if_bp ();
    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) if_nb ();

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .SP_RESET(SP)) dut_bp (
        .clk (clk),
        .rst (rst),
        .bus (if_bp.slave)
    );

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .SP_RESET(SP)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (if_nb.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] bp1;
        logic [31:0] bp2;
        logic [31:0] nb1;
        logic [31:0] nb2;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    logic        m_err;
    int          n_checks = 0;
    int          n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input string field,
                         input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s.%s got %h want %h", name, field, got, want);
        end
    endtask

    // Model read: x0 is zero, a live write forwards when bypass is on, else storage.
    function automatic logic [31:0] m_read(input bit bp, input bit r, input bit we,
                                           input logic [4:0] rdv, input logic [31:0] wd,
                                           input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (bp && !r && we && rdv == rs) return wd;
        return m_regs[rs];
    endfunction

    task automatic drive(input bit r, input bit we, input logic [4:0] rdv,
                         input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst              = r;
        if_bp.reg_write  = we;
        if_bp.rd         = rdv;
        if_bp.write_data = wd;
        if_bp.rs1        = a;
        if_bp.rs2        = b;
        if_nb.reg_write  = we;
        if_nb.rd         = rdv;
        if_nb.write_data = wd;
        if_nb.rs1        = a;
        if_nb.rs2        = b;
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = (i == 2) ? SP : 32'h0;
            m_err = 1'b0;
        end
        e.name = name;
        e.bp1  = m_read(1'b1, r, we, rdv, wd, a);
        e.bp2  = m_read(1'b1, r, we, rdv, wd, b);
        e.nb1  = m_read(1'b0, r, we, rdv, wd, a);
        e.nb2  = m_read(1'b0, r, we, rdv, wd, b);
        e.err  = m_err;
        q.push_back(e);
        // Effect of the coming rising edge.
        if (!r && we) begin
            if (rdv == 5'd0) m_err = 1'b1;
            else m_regs[rdv] = wd;
        end
    endtask

    // Monitor: sample just before each rising edge and compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, "bp_rd1", if_bp.read_data1, e.bp1);
                check(e.name, "bp_rd2", if_bp.read_data2, e.bp2);
                check(e.name, "nb_rd1", if_nb.read_data1, e.nb1);
                check(e.name, "nb_rd2", if_nb.read_data2, e.nb2);
                check(e.name, "bp_err", {31'h0, if_bp.x0_write_err}, {31'h0, e.err});
                check(e.name, "nb_err", {31'h0, if_nb.x0_write_err}, {31'h0, e.err});
            end
        end
    end

    initial begin
        bit          r;
        bit          we;
        logic [4:0]  rdv;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] wd;
        int          k;

        rst              = 1'b1;
        if_bp.reg_write  = 1'b0;
        if_bp.rd         = '0;
        if_bp.write_data = '0;
        if_bp.rs1        = '0;
        if_bp.rs2        = '0;
        if_nb.reg_write  = 1'b0;
        if_nb.rd         = '0;
        if_nb.write_data = '0;
        if_nb.rs1        = '0;
        if_nb.rs2        = '0;
        foreach (m_regs[i]) m_regs[i] = (i == 2) ? SP : 32'h0;
        m_err = 1'b0;

        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd2, "reset_vals");
        drive(1'b0, 1'b1, 5'd1, 32'h1234_5678, 5'd1, 5'd31, "wr_x1");
        drive(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1, 5'd31, "wr_x31");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, "rd_x1_x31");
        drive(1'b0, 1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, "wr_x0");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd2, "x0_after");
        drive(1'b0, 1'b1, 5'd7, 32'h1, 5'd3, 5'd4, "wr_x7_1");
        drive(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7, "bypass_x7");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "x7_after");
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, "wr_x5");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, "rd_x5");
        drive(1'b1, 1'b1, 5'd9, 32'h55, 5'd5, 5'd2, "rst_mid");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, "rst_wr_drop");

        for (int n = 0; n < 10000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            we  = 1'($urandom_range(0, 1));
            rdv = 5'($urandom_range(0, 31));
            wd  = $urandom;
            a   = ($urandom_range(0, 3) == 0) ? rdv : 5'($urandom_range(0, 31));
            b   = ($urandom_range(0, 3) == 0) ? rdv : 5'($urandom_range(0, 31));
            drive(r, we, rdv, wd, a, b, "random");
        end

        k = 0;
        while (q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #5;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
